// File: rtl/cache_types_pkg.sv
// cache_types_pkg: shared FSM states, way type and datapath mux encodings for cache_ctrl
package cache_types_pkg;
   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
   typedef logic way_t;
   localparam logic DSRC_CPU  = 1'b0;
   localparam logic DSRC_PMEM = 1'b1;
   localparam logic ADDR_CPU  = 1'b0;
   localparam logic ADDR_WB   = 1'b1;
   function automatic logic [1:0] way_onehot(way_t w);
      return w ? 2'b10 : 2'b01;
   endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU request, datapath status/control and pmem handshake bundle
interface cache_ctrl_if #(parameter int s_index = 3);
   logic               cpu_read;
   logic               cpu_write;
   logic [s_index-1:0] set_index;
   logic [1:0]         hit;
   logic [1:0]         dirty;
   logic               cpu_resp;
   logic               pmem_read;
   logic               pmem_write;
   logic               pmem_resp;
   logic               array_read;
   logic [1:0]         data_load;
   logic [1:0]         tag_load;
   logic [1:0]         valid_load;
   logic [1:0]         dirty_load;
   logic               dirty_in;
   logic               way_sel;
   logic               data_src;
   logic               addr_sel;
   modport master (
      input  cpu_read, cpu_write, set_index, hit, dirty, pmem_resp,
      output cpu_resp, pmem_read, pmem_write, array_read, data_load, tag_load,
             valid_load, dirty_load, dirty_in, way_sel, data_src, addr_sel
   );
   modport slave (
      output cpu_read, cpu_write, set_index, hit, dirty, pmem_resp,
      input  cpu_resp, pmem_read, pmem_write, array_read, data_load, tag_load,
             valid_load, dirty_load, dirty_in, way_sel, data_src, addr_sel
   );
endinterface

// File: rtl/cache_ctrl_lru_array.sv
// lru_array: one LRU bit per set naming the next victim way; combinational read, one write port
module lru_array #(parameter int s_index = 3) (
   input  logic               clk,
   input  logic               rst,
   input  logic [s_index-1:0] idx,
   input  logic               we,
   input  logic               wdata,
   output logic               rdata
);
   logic [2**s_index-1:0] mem_q, mem_d;
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[idx] = wdata;
   end
   always_ff @(posedge clk) mem_q <= rst ? '0 : mem_d;
   assign rdata = mem_q[idx];
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: 2-way set-associative write-back cache control FSM with per-set LRU
module cache_ctrl
   import cache_types_pkg::*;
#(parameter int s_index = 3) (
   input logic         clk,
   input logic         rst,
   cache_ctrl_if.master bus
);
   state_t state_q, state_d;
   way_t   victim_q, victim_d;
   way_t   hit_way;
   logic   lru_we, lru_wdata, lru_rd, req;

   lru_array #(.s_index(s_index)) u_lru (
      .clk(clk), .rst(rst), .idx(bus.set_index),
      .we(lru_we), .wdata(lru_wdata), .rdata(lru_rd)
   );

   assign req     = bus.cpu_read | bus.cpu_write;
   assign hit_way = bus.hit[0] ? 1'b0 : 1'b1;

   always_comb begin
      state_d        = state_q;
      victim_d       = victim_q;
      lru_we         = 1'b0;
      lru_wdata      = 1'b0;
      bus.cpu_resp   = 1'b0;
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;
      bus.array_read = 1'b0;
      bus.data_load  = '0;
      bus.tag_load   = '0;
      bus.valid_load = '0;
      bus.dirty_load = '0;
      bus.dirty_in   = 1'b0;
      bus.way_sel    = 1'b0;
      bus.data_src   = DSRC_CPU;
      bus.addr_sel   = ADDR_CPU;
      case (state_q)
         IDLE: begin
            bus.array_read = 1'b1;
            state_d        = req ? COMPARE : IDLE;
         end
         COMPARE: begin
            bus.array_read = 1'b1;
            if (!req) state_d = IDLE;
            else if (|bus.hit) begin
               bus.cpu_resp = 1'b1;
               bus.way_sel  = hit_way;
               lru_we       = 1'b1;
               lru_wdata    = ~hit_way;
               if (bus.cpu_write) begin
                  bus.data_load  = way_onehot(hit_way);
                  bus.dirty_load = way_onehot(hit_way);
                  bus.dirty_in   = 1'b1;
               end
               state_d = IDLE;
            end else begin
               victim_d = lru_rd;
               state_d  = bus.dirty[lru_rd] ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            bus.pmem_write = 1'b1;
            bus.addr_sel   = ADDR_WB;
            bus.way_sel    = victim_q;
            if (bus.pmem_resp) state_d = ALLOCATE;
         end
         default: begin
            bus.pmem_read = 1'b1;
            bus.way_sel   = victim_q;
            if (bus.pmem_resp) begin
               bus.data_load  = way_onehot(victim_q);
               bus.tag_load   = way_onehot(victim_q);
               bus.valid_load = way_onehot(victim_q);
               bus.dirty_load = way_onehot(victim_q);
               bus.data_src   = DSRC_PMEM;
               state_d        = COMPARE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      state_q  <= rst ? IDLE : state_d;
      victim_q <= rst ? 1'b0 : victim_d;
   end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scoreboard bench; stimulus queues expected output events, monitor checks them
module tb_cache_ctrl;
   import cache_types_pkg::*;
   typedef struct packed {
      logic resp; logic [1:0] dl, tl, vl, dyl; logic din, dsrc, way;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   ev_t  q[$];

   cache_ctrl_if #(.s_index(3)) bus();
   cache_ctrl #(.s_index(3)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   function automatic ev_t hit_ev(input logic wr, input logic w);
      logic [1:0] oh;
      oh = w ? 2'b10 : 2'b01;
      return wr ? {1'b1, oh, 2'b00, 2'b00, oh, 1'b1, 1'b0, w}
                : {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, w};
   endfunction

   function automatic ev_t fill_ev(input logic v);
      logic [1:0] oh;
      oh = v ? 2'b10 : 2'b01;
      return {1'b0, oh, oh, oh, oh, 1'b0, 1'b1, v};
   endfunction

   task automatic idle_in();
      bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.set_index = '0;
      bus.hit = '0; bus.dirty = '0; bus.pmem_resp = 1'b0;
   endtask

   task automatic hit_txn(input logic rd, input logic wr, input logic [2:0] idx,
                          input logic [1:0] h, input logic exp_way);
      q.push_back(hit_ev(wr, exp_way));
      bus.cpu_read = rd; bus.cpu_write = wr; bus.set_index = idx; bus.hit = h;
      tick();
      samp();
      tick();
      idle_in();
   endtask

   task automatic miss_txn(input logic wr, input logic [2:0] idx, input logic [1:0] d,
                           input logic v, input int nwb, input int nal);
      bus.cpu_read = !wr; bus.cpu_write = wr; bus.set_index = idx;
      bus.hit = 2'b00; bus.dirty = d;
      tick();
      samp();
      chk("cmp_no_pmem", {bus.pmem_read, bus.pmem_write}, 0);
      tick();
      for (int i = 0; i < nwb; i++) begin
         bus.pmem_resp = (i == nwb - 1);
         samp();
         chk("wb_hold", {bus.pmem_write, bus.pmem_read, bus.addr_sel, bus.way_sel}, {3'b101, v});
         tick();
         bus.pmem_resp = 1'b0;
      end
      for (int i = 0; i < nal; i++) begin
         bus.pmem_resp = (i == nal - 1);
         if (i == nal - 1) q.push_back(fill_ev(v));
         samp();
         chk("al_hold", {bus.pmem_read, bus.pmem_write, bus.addr_sel, bus.way_sel}, {3'b100, v});
         tick();
         bus.pmem_resp = 1'b0;
      end
      bus.hit = v ? 2'b10 : 2'b01;
      q.push_back(hit_ev(wr, v));
      samp();
      tick();
      idle_in();
   endtask

   initial begin
      forever begin
         ev_t e;
         samp();
         e = {bus.cpu_resp, bus.data_load, bus.tag_load, bus.valid_load, bus.dirty_load,
              bus.dirty_in, bus.data_src, bus.way_sel};
         if (!rst && (e.resp || |{e.dl, e.tl, e.vl, e.dyl})) begin
            if (q.size() == 0) chk("unexpected_event", e, 0);
            else chk("event", e, q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      idle_in();
      rst = 1'b1;
      repeat (2) tick();
      samp();
      chk("rst_resp", bus.cpu_resp, 0);
      chk("rst_pmem", {bus.pmem_read, bus.pmem_write}, 0);
      chk("rst_loads", {bus.data_load, bus.tag_load, bus.valid_load, bus.dirty_load}, 0);
      chk("rst_array_read", bus.array_read, 1);
      chk("rst_mux", {bus.way_sel, bus.data_src, bus.addr_sel, bus.dirty_in}, 0);
      rst = 1'b0;
      tick();

      hit_txn(1'b1, 1'b0, 3'd3, 2'b01, 1'b0);
      chk("lru3", dut.u_lru.mem_q[3], 1);
      hit_txn(1'b1, 1'b0, 3'd5, 2'b01, 1'b0);
      chk("lru5_a", dut.u_lru.mem_q[5], 1);
      hit_txn(1'b0, 1'b1, 3'd5, 2'b10, 1'b1);
      chk("lru5_b", dut.u_lru.mem_q[5], 0);
      hit_txn(1'b1, 1'b1, 3'd1, 2'b01, 1'b0);
      chk("lru1", dut.u_lru.mem_q[1], 1);
      hit_txn(1'b1, 1'b0, 3'd4, 2'b11, 1'b0);
      chk("lru4", dut.u_lru.mem_q[4], 1);

      miss_txn(1'b0, 3'd2, 2'b00, 1'b0, 0, 10);
      chk("lru2", dut.u_lru.mem_q[2], 1);

      hit_txn(1'b1, 1'b0, 3'd7, 2'b01, 1'b0);
      chk("lru7_a", dut.u_lru.mem_q[7], 1);
      miss_txn(1'b1, 3'd7, 2'b10, 1'b1, 3, 4);
      chk("lru7_b", dut.u_lru.mem_q[7], 0);

      bus.cpu_read = 1'b1; bus.hit = 2'b01;
      tick();
      bus.cpu_read = 1'b0;
      samp();
      tick();
      chk("norq_idle", dut.state_q, IDLE);
      bus.hit = 2'b00;

      bus.pmem_resp = 1'b1;
      samp();
      chk("stray_pmem", {bus.pmem_read, bus.pmem_write}, 0);
      tick();
      tick();
      chk("stray_idle", dut.state_q, IDLE);
      bus.pmem_resp = 1'b0;

      hit_txn(1'b1, 1'b0, 3'd6, 2'b01, 1'b0);
      bus.cpu_read = 1'b1; bus.set_index = 3'd6; bus.hit = 2'b00; bus.dirty = 2'b10;
      tick();
      tick();
      samp();
      chk("wb_pre_rst", {bus.pmem_write, bus.addr_sel, bus.way_sel}, 3'b111);
      rst = 1'b1;
      tick();
      chk("rst_wb_pmem", {bus.pmem_read, bus.pmem_write}, 0);
      chk("rst_wb_state", dut.state_q, IDLE);
      chk("rst_wb_victim", dut.victim_q, 0);
      chk("rst_wb_lru", dut.u_lru.mem_q, 0);
      rst = 1'b0;
      idle_in();
      tick();

      hit_txn(1'b1, 1'b0, 3'd3, 2'b10, 1'b1);
      chk("lru3_post", dut.u_lru.mem_q[3], 0);

      repeat (3) tick();
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
